// File: rtl/clk_div_pkg.sv
// ----------------------------------------------------------------------------
// clk_div_pkg
//   Shared constants, width helper and per-channel configuration record for the
//   clk_div_bank slow-clock / clock-enable generator.
//
//   CNT_W_DEF       : default divisor/counter width. It is also the storage
//                     width of ch_cfg_t, so instances must use CNT_W <= 32.
//   DEFAULT_DIV_DEF : reset half-period in clk cycles (1 Hz at 100 MHz).
//   ch_width()      : channel-index width, max(1, clog2(n)).
//   ch_cfg_t        : active divisor, staged divisor and staged-valid flag.
// ----------------------------------------------------------------------------
package clk_div_pkg;

    localparam int unsigned CNT_W_DEF       = 32;
    localparam int unsigned DEFAULT_DIV_DEF = 50_000_000;

    function automatic int unsigned ch_width(input int unsigned n);
        int unsigned w;
        if (n <= 1) begin
            w = 1;
        end else begin
            w = $clog2(n);
        end
        return w;
    endfunction

    typedef struct packed {
        logic [CNT_W_DEF-1:0] div;      // half-period currently in use
        logic [CNT_W_DEF-1:0] shadow;   // accepted value waiting for a boundary
        logic                 pending;  // shadow holds an unapplied divisor
    } ch_cfg_t;

endpackage

// File: rtl/clk_div_bank_if.sv
// ----------------------------------------------------------------------------
// clk_div_bank_if
//   Configuration write port of clk_div_bank.
//
//   cfg_we    : write request
//   cfg_ch    : target channel index (CH_W bits)
//   cfg_div   : new half-period count (0 is treated as 1)
//   cfg_ready : selected channel can take a write (combinational)
//
//   master : the agent issuing writes
//   slave  : clk_div_bank
// ----------------------------------------------------------------------------
interface clk_div_bank_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = clk_div_pkg::CNT_W_DEF
);
    import clk_div_pkg::*;

    localparam int unsigned CH_W = ch_width(NUM_CH);

    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;

    modport master (
        output cfg_we,
        output cfg_ch,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_we,
        input  cfg_ch,
        input  cfg_div,
        output cfg_ready
    );

endinterface

// File: rtl/clk_div_ch.sv
// ----------------------------------------------------------------------------
// clk_div_ch
//   One divider channel: half-period counter, 50% square wave, one-cycle tick
//   on each rising edge, staged divisor applied glitch-free at a half-period
//   boundary, and stop/restart control.
//
//   clk        : system clock
//   rst_n      : synchronous active-low reset
//   run_i      : channel runs while high; low forces counter/outputs to 0
//   sync_i     : restart the phase (counter=0, slow_clk=0) on this edge
//   wr_i       : accepted config write for this channel (only while !pending)
//   wr_div_i   : written half-period; 0 is stored as 1
//   pending_o  : a staged divisor has not been applied yet
//   slow_clk_o : divided square wave (registered)
//   tick_o     : one-cycle pulse with each slow_clk rise (registered)
//
//   CNT_W must not exceed clk_div_pkg::CNT_W_DEF (storage width of ch_cfg_t).
// ----------------------------------------------------------------------------
module clk_div_ch #(
    parameter int unsigned      CNT_W       = clk_div_pkg::CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(clk_div_pkg::DEFAULT_DIV_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wr_div_i,
    output logic             pending_o,
    output logic             slow_clk_o,
    output logic             tick_o
);
    import clk_div_pkg::*;

    ch_cfg_t          cfg_q, cfg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             slow_q, slow_d;
    logic             tick_q, tick_d;

    logic [CNT_W-1:0] div_cur;
    logic [CNT_W-1:0] wr_div_c;
    logic             wrap;
    logic             boundary;

    always_comb begin
        cfg_d    = cfg_q;
        cnt_d    = cnt_q;
        slow_d   = slow_q;
        tick_d   = 1'b0;
        div_cur  = cfg_q.div[CNT_W-1:0];
        wr_div_c = (wr_div_i == '0) ? CNT_W'(1) : wr_div_i;
        // div_cur is never 0, so div_cur-1 cannot underflow; >= keeps the
        // counter from running away should it ever exceed the limit.
        wrap     = (cnt_q >= div_cur - CNT_W'(1));
        boundary = 1'b0;

        if (!run_i) begin
            cnt_d    = '0;
            slow_d   = 1'b0;
            boundary = 1'b1;
        end else if (sync_i) begin
            cnt_d    = '0;
            slow_d   = 1'b0;
            boundary = 1'b1;
        end else if (wrap) begin
            cnt_d    = '0;
            slow_d   = !slow_q;
            tick_d   = !slow_q;
            boundary = 1'b1;
        end else begin
            cnt_d    = cnt_q + CNT_W'(1);
        end

        // Stop, sync and wrap all start a fresh half-period, so a staged
        // divisor can take over without shortening the current one.
        if (cfg_q.pending && boundary) begin
            cfg_d.div     = cfg_q.shadow;
            cfg_d.pending = 1'b0;
        end

        // wr_i is only raised while pending is clear, so it never collides
        // with the apply above.
        if (wr_i) begin
            cfg_d.shadow  = CNT_W_DEF'(wr_div_c);
            cfg_d.pending = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_q.div     <= CNT_W_DEF'(DEFAULT_DIV);
            cfg_q.shadow  <= '0;
            cfg_q.pending <= 1'b0;
            cnt_q         <= '0;
            slow_q        <= 1'b0;
            tick_q        <= 1'b0;
        end else begin
            cfg_q  <= cfg_d;
            cnt_q  <= cnt_d;
            slow_q <= slow_d;
            tick_q <= tick_d;
        end
    end

    assign pending_o  = cfg_q.pending;
    assign slow_clk_o = slow_q;
    assign tick_o     = tick_q;

endmodule

// File: rtl/clk_div_bank.sv
// ----------------------------------------------------------------------------
// clk_div_bank
//   Multi-channel programmable slow-clock / clock-enable generator. Each
//   channel outputs a 50%-duty square wave with half-period div and a one-cycle
//   tick on every rising edge. Divisors are loaded at runtime through cfg_if
//   and take effect only at half-period boundaries.
//
//   clk      : system clock (only clock)
//   rst_n    : synchronous active-low reset
//   sync_req : (CLKDIV_SYNC_EN only) phase-align all running channels
//   cfg_if   : config write port (cfg_we, cfg_ch, cfg_div, cfg_ready)
//   run_en   : per-channel run enable
//   slow_clk : per-channel divided square wave
//   tick     : per-channel pulse coincident with each slow_clk rise
//
//   Build option: define CLKDIV_SYNC_EN to add the sync_req input. Without it
//   the channels free-run independently.
// ----------------------------------------------------------------------------
module clk_div_bank #(
    parameter int unsigned      NUM_CH      = 4,
    parameter int unsigned      CNT_W       = clk_div_pkg::CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(clk_div_pkg::DEFAULT_DIV_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef CLKDIV_SYNC_EN
    input  logic              sync_req,
`endif
    clk_div_bank_if.slave     cfg_if,
    input  logic [NUM_CH-1:0] run_en,
    output logic [NUM_CH-1:0] slow_clk,
    output logic [NUM_CH-1:0] tick
);
    import clk_div_pkg::*;

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] wr_en;
    logic              ready;
    logic              sync;

`ifdef CLKDIV_SYNC_EN
    assign sync = sync_req;
`else
    assign sync = 1'b0;
`endif

    // An index past the last channel selects nothing: ready stays low and no
    // write strobe is raised, so the write is dropped.
    always_comb begin
        ready = 1'b0;
        wr_en = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(cfg_if.cfg_ch) == i) begin
                ready    = !pending[i];
                wr_en[i] = cfg_if.cfg_we && !pending[i];
            end
        end
    end

    assign cfg_if.cfg_ready = ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_ch #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .run_i      (run_en[g]),
            .sync_i     (sync),
            .wr_i       (wr_en[g]),
            .wr_div_i   (cfg_if.cfg_div),
            .pending_o  (pending[g]),
            .slow_clk_o (slow_clk[g]),
            .tick_o     (tick[g])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
`timescale 1ns/1ps
module tb_clk_div_bank;

    localparam int unsigned NCH = 4;
    localparam int R = 4;            // cycle at which reset is released
`ifdef CLKDIV_SYNC_EN
    localparam int S     = R + 140;
    localparam int W01   = S + 45;
    localparam int T_END = S + 50;
`else
    localparam int W01   = R + 135;
    localparam int T_END = R + 140;
`endif
    localparam int W23 = R + 135;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] run_en;
    logic [NCH-1:0] slow_clk;
    logic [NCH-1:0] tick;
`ifdef CLKDIV_SYNC_EN
    logic           sync_req;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    clk_div_bank_if #(.NUM_CH(NCH), .CNT_W(32)) cfg_if ();

    clk_div_bank #(
        .NUM_CH      (NCH),
        .CNT_W       (32),
        .DEFAULT_DIV (32'd5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef CLKDIV_SYNC_EN
        .sync_req (sync_req),
`endif
        .cfg_if   (cfg_if),
        .run_en   (run_en),
        .slow_clk (slow_clk),
        .tick     (tick)
    );

    // kind: 0 = slow_clk[ch], 1 = cfg_ready, 2 = tick[ch]
    typedef struct {
        int   cyc;
        int   kind;
        int   ch;
        logic val;
    } lvl_t;

    lvl_t lvl_q[$];
    int   tick_q[NCH][$];
    int   n_assert = 0;
    int   n_fail   = 0;
    logic done     = 1'b0;

    task automatic lv(input int c, input int kind, input int ch, input logic val);
        lvl_t e;
        e.cyc = c; e.kind = kind; e.ch = ch; e.val = val;
        lvl_q.push_back(e);
    endtask

    task automatic tk(input int ch, input int first, input int last, input int step);
        for (int c = first; c <= last; c += step) tick_q[ch].push_back(c);
    endtask

    // Hand-computed expectations (cycle n = values visible after posedge n).
    task automatic setup();
        for (int c = 0; c < int'(NCH); c++) begin
            lv(3, 0, c, 1'b0);
            lv(3, 2, c, 1'b0);
        end
        lv(3, 1, 0, 1'b1);
        lv(R+4, 0, 0, 1'b0);  lv(R+5, 0, 0, 1'b1);
        lv(R+9, 0, 0, 1'b1);  lv(R+10, 0, 0, 1'b0);
        lv(R+37, 1, 0, 1'b1); lv(R+38, 1, 0, 1'b0);
        lv(R+39, 1, 0, 1'b0); lv(R+39, 0, 1, 1'b1);
        lv(R+40, 1, 0, 1'b1); lv(R+40, 0, 1, 1'b0);
        lv(R+42, 0, 1, 1'b0); lv(R+43, 0, 1, 1'b1);
        lv(R+45, 0, 1, 1'b1); lv(R+46, 0, 1, 1'b0);
        lv(R+66, 0, 2, 1'b0); lv(R+67, 0, 2, 1'b1); lv(R+68, 0, 2, 1'b0);
        lv(R+86, 0, 0, 1'b1); lv(R+87, 0, 0, 1'b0); lv(R+90, 0, 0, 1'b0);
        lv(R+96, 0, 0, 1'b0); lv(R+97, 0, 0, 1'b1);
        lv(R+111, 1, 0, 1'b0); lv(R+112, 1, 0, 1'b0);
        for (int c = 0; c < int'(NCH); c++) lv(R+113, 0, c, 1'b0);
        lv(R+113, 1, 0, 1'b1);
        lv(R+117, 0, 3, 1'b0); lv(R+118, 0, 3, 1'b1);
        lv(R+122, 0, 3, 1'b1); lv(R+123, 0, 3, 1'b0);
`ifdef CLKDIV_SYNC_EN
        lv(S+2, 0, 0, 1'b0);
        lv(S+21, 0, 0, 1'b0); lv(S+21, 0, 1, 1'b0);
        lv(S+25, 0, 0, 1'b1); lv(S+25, 0, 1, 1'b1);
`endif
        tk(0, R+5, R+85, 10);  tk(0, R+97, R+107, 10); tk(0, R+118, R+128, 10);
        tk(1, R+5, R+35, 10);  tk(1, R+43, R+109, 6);  tk(1, R+118, R+128, 10);
        tk(2, R+5, R+55, 10);  tk(2, R+65, R+111, 2);  tk(2, R+118, R+128, 10);
        tk(3, R+5, R+105, 10); tk(3, R+118, R+128, 10);
`ifdef CLKDIV_SYNC_EN
        tk(0, R+138, R+138, 10); tk(0, S+7, S+15, 8); tk(0, S+25, S+41, 8);
        tk(1, R+138, R+138, 10); tk(1, S+9, S+17, 8); tk(1, S+25, S+41, 8);
`endif
    endtask

    task automatic check_levels();
        lvl_t e;
        logic act;
        while (lvl_q.size() > 0 && lvl_q[0].cyc <= cyc) begin
            e = lvl_q.pop_front();
            case (e.kind)
                0:       act = slow_clk[e.ch];
                1:       act = cfg_if.cfg_ready;
                default: act = tick[e.ch];
            endcase
            n_assert++;
            if (e.cyc != cyc || act !== e.val) begin
                n_fail++;
                $display("FAIL level kind%0d ch%0d cycle %0d: got %b, required %b",
                         e.kind, e.ch, e.cyc, act, e.val);
            end
        end
    endtask

    task automatic check_ticks();
        int wend;
        int dummy;
        for (int c = 0; c < int'(NCH); c++) begin
            wend = (c < 2) ? W01 : W23;
            if (cyc >= R+1 && cyc <= wend) begin
                while (tick_q[c].size() > 0 && tick_q[c][0] < cyc) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL tick_missed ch%0d: no tick at cycle %0d, required tick=1",
                             c, tick_q[c][0]);
                    dummy = tick_q[c].pop_front();
                end
                if (tick[c] === 1'b1) begin
                    n_assert++;
                    if (tick_q[c].size() > 0 && tick_q[c][0] == cyc) begin
                        dummy = tick_q[c].pop_front();
                    end else begin
                        n_fail++;
                        $display("FAIL tick_unexpected ch%0d cycle %0d: got tick=1, required 0",
                                 c, cyc);
                    end
                end
            end
        end
    endtask

    // Monitor / scoreboard
    initial begin
        setup();
        forever begin
            @(negedge clk);
            if (done) break;
            check_levels();
            check_ticks();
        end
        for (int c = 0; c < int'(NCH); c++) begin
            while (tick_q[c].size() > 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL tick_missed ch%0d: no tick at cycle %0d, required tick=1",
                         c, tick_q[c].pop_front());
            end
        end
        while (lvl_q.size() > 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL level_unchecked cycle %0d: got no sample, required %b",
                     lvl_q[0].cyc, lvl_q[0].val);
            void'(lvl_q.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    task automatic go(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Stimulus
    initial begin
        rst_n          = 1'b0;
        run_en         = '1;
        cfg_if.cfg_we  = 1'b0;
        cfg_if.cfg_ch  = '0;
        cfg_if.cfg_div = '0;
`ifdef CLKDIV_SYNC_EN
        sync_req       = 1'b0;
`endif
        go(R);     rst_n = 1'b1;
        // ch1: write div=3 while its counter is at 2, then a write while pending
        go(R+37);  cfg_if.cfg_ch = 2'd1; cfg_if.cfg_div = 32'd3; cfg_if.cfg_we = 1'b1;
        go(R+38);  cfg_if.cfg_div = 32'd7;
        go(R+39);  cfg_if.cfg_we = 1'b0;
        // ch2: div=0 behaves as div=1
        go(R+60);  cfg_if.cfg_ch = 2'd2; cfg_if.cfg_div = 32'd0; cfg_if.cfg_we = 1'b1;
        go(R+61);  cfg_if.cfg_we = 1'b0;
        // ch0: stop while high, restart
        go(R+86);  run_en[0] = 1'b0;
        go(R+92);  run_en[0] = 1'b1;
        // ch3: pending write aborted by reset
        go(R+110); cfg_if.cfg_ch = 2'd3; cfg_if.cfg_div = 32'd9; cfg_if.cfg_we = 1'b1;
        go(R+111); cfg_if.cfg_we = 1'b0;
        go(R+112); rst_n = 1'b0;
        go(R+113); rst_n = 1'b1;
`ifdef CLKDIV_SYNC_EN
        go(S);     run_en = 4'b1100;
                   cfg_if.cfg_ch = 2'd0; cfg_if.cfg_div = 32'd4; cfg_if.cfg_we = 1'b1;
        go(S+1);   cfg_if.cfg_ch = 2'd1;
        go(S+2);   cfg_if.cfg_we = 1'b0;
        go(S+3);   run_en[0] = 1'b1;
        go(S+5);   run_en[1] = 1'b1;
        go(S+20);  sync_req = 1'b1;
        go(S+21);  sync_req = 1'b0;
`endif
        go(T_END); done = 1'b1;
    end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Multi-channel programmable clock-enable / slow-clock generator; parametrised successor to the fixed single-output slow-clock divider.
- Each channel produces a 50%-duty square wave plus a one-cycle tick.
- Divisors are runtime-loadable through a config handshake, and each channel has its own run control.
- Sits between the board clock and I/O consumers: LED blink, display scan, debounce sampling, UART baud ticks.

Parameters:
- NUM_CH, 4, number of independent channels (1..16).
- CNT_W, 32, width of divisor and counter.
- DEFAULT_DIV, 50000000, reset half-period in clk cycles (1 Hz at 100 MHz).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- cfg_we  in  1  config write request.
- cfg_ch  in  CH_W  target channel index, CH_W = max(1, clog2(NUM_CH)).
- cfg_div  in  CNT_W  new half-period count.
- cfg_ready  out  1  selected channel can accept a write.
- run_en  in  NUM_CH  per-channel run enable.
- slow_clk  out  NUM_CH  divided square wave per channel.
- tick  out  NUM_CH  one-cycle pulse per channel, coincident with each slow_clk rising edge.

Behaviour:
- Reset is synchronous, active-low, one clock; clk is the only clock. While rst_n=0 at a clk edge: div_reg=DEFAULT_DIV, shadow=0, pending=0, counter=0, slow_clk=0, tick=0.
- All outputs are registered except cfg_ready, which is combinational: cfg_ready = !pending[cfg_ch].

Running channel (run_en=1):
- counter increments every cycle.
- When counter==div_reg-1: counter goes to 0 and slow_clk toggles on the next edge.
- If the toggle is 0->1, tick=1 for exactly that cycle; tick=0 otherwise.
- Output period is 2*div_reg cycles with exactly div_reg high and div_reg low. tick period is 2*div_reg.
- div_reg=1 gives slow_clk = clk/2 with tick high every other cycle.

Stopped channel (run_en=0):
- On the next edge, counter=0, slow_clk=0, tick=0; these are held while stopped.
- On re-enable, the first toggle (0->1 with tick) occurs div_reg cycles after the enabling edge.

Config write:
- A write is accepted when cfg_we && cfg_ready at a clk edge; a write with cfg_ready=0 is ignored (no error, no queueing).
- cfg_ch >= NUM_CH is ignored.
- cfg_div=0 is clamped to 1.
- An accepted write loads shadow[ch] and sets pending[ch].

Glitch-free apply:
- A pending divisor is applied to a running channel only at a half-period boundary, on the same edge where counter wraps to 0. On that edge div_reg=shadow and pending clears. The current half-period always completes with the old divisor.
- A pending divisor on a stopped channel is applied on the next edge, with counter=0.

Simultaneous events:
- Reset beats everything.
- run_en falling and a wrap on the same edge: stop wins (slow_clk=0, tick=0), but a pending divisor is still applied.
- A write accepted on the same edge as the apply of the previous pending value cannot occur, because cfg_ready was low.

Reset mid-operation aborts any pending update; the divisor returns to DEFAULT_DIV.

Optional Feature:
- Macro: CLKDIV_SYNC_EN.
- Defined: adds input sync_req (1 bit). On an edge with sync_req=1, every running channel gets counter=0 and slow_clk=0 (tick=0), and any pending divisor is applied immediately. All channels become phase-aligned: channels with equal divisors produce coincident ticks thereafter. sync_req has priority over a normal wrap; reset has priority over sync_req.
- Undefined: the port is absent and channels free-run independently.

Decomposition:
- Package clk_div_pkg holds:
  - the CNT_W default and DEFAULT_DIV constant;
  - the CH_W width helper function;
  - a per-channel config struct typedef {div, shadow, pending}.
- Natural sub-module: clk_div_ch, one channel with counter, toggle, tick, shadow apply and stop logic.
- The top instantiates NUM_CH copies with a generate loop and holds cfg decode plus cfg_ready muxing.

Test Plan:
- Reset, NUM_CH=4, DEFAULT_DIV=5, all run_en=1 -> each slow_clk has period 10 (5 high/5 low); first tick 5 cycles after reset release; tick high 1 cycle per 10.
- Mid-half-period write ch1 div=3 at counter=2 -> cfg_ready low until the wrap at counter=4; then 3-cycle half-periods; no runt pulse; second write while pending is ignored.
- Write ch2 cfg_div=0 -> behaves as div=1: slow_clk toggles every cycle, tick every 2 cycles.
- Drop run_en[0] while slow_clk[0]=1 -> next edge slow_clk[0]=0 and held; raise again -> rising edge plus tick exactly div cycles later.
- Assert rst_n=0 for one cycle while ch3 has a pending write -> all outputs 0, pending cleared, ch3 restarts with DEFAULT_DIV.
- With CLKDIV_SYNC_EN, ch0 div=4, ch1 div=4 started 2 cycles apart, pulse sync_req -> from the next edge tick[0] and tick[1] coincide on every period.
